load_store_unit: RTL
====================

# load_store_unit

Initiator-side memory access unit between the MEM pipeline stage and the word-addressed data memory (32-bit words, combinational read, synchronous write). It accepts one byte/halfword/word load or store per handshake and converts the byte address into a word index. Sub-word stores are done as a two-cycle read-modify-write, and loads are sign- or zero-extended. Misaligned and out-of-range accesses are flagged and never reach memory.

## Interface
- MEM_WORDS, 1024, data memory depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- reqValid  in  1  request present
- reqReady  out  1  unit can accept; high only in IDLE
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- reqSigned  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
- reqAddr  in  32  byte address
- reqWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- respValid  out  1  one-cycle completion pulse
- respRData  out  32  load result, extended; 0 for stores and errors
- respError  out  1  valid with respValid: misaligned, out of range or illegal size
- memAddress  out  32  word index = latched reqAddr[31:2]
- memWriteEnable  out  1  memory write strobe
- memDataWrite  out  32  word written to memory
- memDataOutput  in  32  combinational read data for memAddress

## Operation
- States: IDLE, ACCESS, MERGE, RESP. State and all outputs are registered or decoded from registered state only.
- IDLE: reqReady=1. On reqValid, latch write, size, signed, addr and wdata.
  - Error condition: size 11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS. On error go to RESP with the error flag set.
  - Otherwise go to ACCESS.
- ACCESS: memAddress = latched word index.
  - Load: capture the extracted lane into respRData, then go to RESP.
  - Word store: memWriteEnable=1, memDataWrite=wdata, then go to RESP.
  - Sub-word store: capture memDataOutput into a merge register, then go to MERGE.
- MERGE: memWriteEnable=1. memDataWrite = captured word with the target lane replaced:
  - byte: lane addr[1:0], bits [8*lane+7 : 8*lane] = wdata[7:0]
  - half: lane addr[1], bits [16*lane+15 : 16*lane] = wdata[15:0]
  - Then go to RESP.
- RESP: respValid=1 with respRData/respError, then go to IDLE.
- Byte ordering is little-endian. Load extraction uses the same lanes; bit 7 or 15 is the sign bit.
- memWriteEnable is never high in IDLE or RESP, and never high for an errored request.
- Request inputs are ignored while reqReady=0. Changes to reqWData/reqAddr while busy have no effect.
- Reset values: state IDLE, reqReady=1, respValid=0, respRData=0, respError=0, memAddress=0, memWriteEnable=0, memDataWrite=0.
- Reset mid-operation: asserting rst forces IDLE immediately and drops memWriteEnable asynchronously, so the write pending at the next edge is aborted. No respValid is issued for the aborted request.

## Timing
- Accept edge = rising edge with reqValid & reqReady; call it cycle 0.
- Latency from accept edge to respValid:
  - Error: respValid in cycle 1.
  - Load or word store: ACCESS in cycle 1, respValid in cycle 2.
  - Sub-word store: ACCESS in cycle 1, MERGE in cycle 2, respValid in cycle 3.
- Memory write occurs at the end of the single cycle where memWriteEnable=1 (cycle 1 for a word store, cycle 2 for a sub-word store).
- reqReady is low from cycle 1 through the RESP cycle and returns high the cycle after RESP.
- Peak throughput: one request per 3 cycles; one per 4 for sub-word stores.
- There is no response backpressure; the consumer must take respValid when it pulses.

## Test plan
- Word path: word store 0xDEADBEEF at reqAddr 0x10, then word load at 0x10.
  - memAddress=4, memWriteEnable high exactly one cycle (cycle 1).
  - Load gives respRData=0xDEADBEEF with respValid in cycle 2 and respError=0.
- Byte RMW: memory word 4 preloaded 0x11223344; byte store 0xAB at 0x13.
  - Word 4 becomes 0xAB223344 and respValid comes in cycle 3.
  - Signed byte load at 0x13 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Half RMW: word 8 preloaded 0; half store 0x8001 at 0x22.
  - Word 8 becomes 0x80010000.
  - Signed half load at 0x22 returns 0xFFFF8001; unsigned returns 0x00008001.
- Errors: each of the following gives respValid in cycle 1, respError=1, respRData=0, memWriteEnable never asserted:
  - word load at 0x6
  - half store at 0x3
  - word store at 0x1000
  - reqSize=11
- Reset: drop rst while in MERGE.
  - memWriteEnable falls immediately and the target word is unchanged.
  - No respValid; reqReady=1 after release.
- Busy: hold reqValid high continuously with changing reqWData.
  - reqReady is low during each operation, each request is accepted only in IDLE, and only the data latched at accept is written.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte address to word index, sub-word stores as read-modify-write,
// sign/zero-extended loads, misaligned/out-of-range requests rejected before memory.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memDataWrite,
    input  logic [31:0] memDataOutput
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    localparam logic [1:0]  SZ_B = 2'b00;
    localparam logic [1:0]  SZ_H = 2'b01;
    localparam logic [1:0]  SZ_W = 2'b10;
    localparam logic [31:0] MemWords = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [4:0]  sh;
    logic [31:0] word_sh;
    logic [31:0] byte_ext;
    logic [31:0] half_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] merged;

    assign req_err = (reqSize == 2'b11)
                   | ((reqSize == SZ_H) & reqAddr[0])
                   | ((reqSize == SZ_W) & (|reqAddr[1:0]))
                   | ({2'b00, reqAddr[31:2]} >= MemWords);

    // Lane offset in bits; halfword lanes fall out because addr[0] is 0 for them.
    assign sh       = {addr_q[1:0], 3'b000};
    assign word_sh  = memDataOutput >> sh;
    assign byte_ext = {{24{signed_q & word_sh[7]}}, word_sh[7:0]};
    assign half_ext = {{16{signed_q & word_sh[15]}}, word_sh[15:0]};

    assign lane_mask = (size_q == SZ_B) ? (32'h0000_00ff << sh)
                                        : (32'h0000_ffff << sh);
    assign lane_ins  = (size_q == SZ_B) ? ({24'b0, wdata_q[7:0]} << sh)
                                        : ({16'b0, wdata_q[15:0]} << sh);
    assign merged    = (merge_q & ~lane_mask) | lane_ins;

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        size_d         = size_q;
        signed_d       = signed_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        merge_d        = merge_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        reqReady       = 1'b0;
        respValid      = 1'b0;
        memWriteEnable = 1'b0;
        memDataWrite   = 32'b0;
        unique case (state_q)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    write_d  = reqWrite;
                    size_d   = reqSize;
                    signed_d = reqSigned;
                    addr_d   = reqAddr;
                    wdata_d  = reqWData;
                    err_d    = req_err;
                    rdata_d  = 32'b0;
                    state_d  = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    unique case (size_q)
                        SZ_B:    rdata_d = byte_ext;
                        SZ_H:    rdata_d = half_ext;
                        default: rdata_d = memDataOutput;
                    endcase
                    state_d = RESP;
                end else if (size_q == SZ_W) begin
                    memWriteEnable = 1'b1;
                    memDataWrite   = wdata_q;
                    state_d        = RESP;
                end else begin
                    merge_d = memDataOutput;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                memWriteEnable = 1'b1;
                memDataWrite   = merged;
                state_d        = RESP;
            end
            RESP: begin
                respValid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign respRData  = rdata_q;
    assign respError  = err_q;
    assign memAddress = {2'b00, addr_q[31:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            merge_q  <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
